// File: rtl/edit_buffer.sv
// edit_buffer
// -----------
// Cursor-addressed line buffer of `depth` tokens, each `width` bits wide.
// Sits between the keyboard pulse generator and the evaluator; the display
// taps `mem` and `cursor` directly.
//
// Optional feature macro: OVERWRITE_MODE_EN
//   defined   : insert with mode_ovr = 1 and cursor < count overwrites the
//               slot under the cursor (no shift, count unchanged).
//   undefined : mode_ovr is accepted but ignored; insert always shifts.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   dataIn              token to insert
//   insert, del         one-cycle edit pulses (insert at cursor / backspace)
//   ptrLeft, ptrRight   one-cycle cursor move pulses
//   eval                one-cycle pulse, starts stream readout
//   mode_ovr            overwrite mode select (see macro above)
//   out_ready           downstream accepts a token
//   mem                 flattened buffer, slot i at [i*width +: width]
//   cursor, count       insertion point (0..count) and occupancy
//   full, empty         combinational flags from count
//   busy                high while streaming
//   out_data/valid/last stream output
//   err                 registered one-cycle pulse on a rejected command
//   state_dbg           current FSM state (0 = IDLE, 1 = STREAM)
//
// Stream handshake: a token moves when out_valid and out_ready are both high
// at a rising edge; while out_valid is high and out_ready is low, out_data
// and out_last hold their values.
module edit_buffer #(
    parameter int depth         = 20,
    parameter int width         = 8,
    parameter bit CLEAR_ON_EVAL = 1'b1,
    localparam int CW           = $clog2(depth + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [width-1:0]       dataIn,
    input  logic                   insert,
    input  logic                   del,
    input  logic                   ptrLeft,
    input  logic                   ptrRight,
    input  logic                   eval,
    input  logic                   mode_ovr,
    input  logic                   out_ready,
    output logic [depth*width-1:0] mem,
    output logic [CW-1:0]          cursor,
    output logic [CW-1:0]          count,
    output logic                   full,
    output logic                   empty,
    output logic                   busy,
    output logic [width-1:0]       out_data,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   err,
    output logic                   state_dbg
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int            AW       = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] DEPTH_CW = CW'(depth);

    logic [width-1:0] slots_q [depth];
    logic [width-1:0] slots_d [depth];
    logic [CW-1:0]    cursor_q, cursor_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    idx_q, idx_d;
    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic             ovr_hit;
    logic             last_tok;

`ifdef OVERWRITE_MODE_EN
    // Overwrite only applies inside the occupied region; at the end of the
    // line insert falls back to a normal (shifting, full-checked) insert.
    assign ovr_hit = mode_ovr && (cursor_q < count_q);
`else
    logic unused_mode_ovr;
    assign unused_mode_ovr = mode_ovr;
    assign ovr_hit         = 1'b0;
`endif

    assign last_tok = (idx_q == count_q - ONE);

    always_comb begin
        slots_d  = slots_q;
        cursor_d = cursor_q;
        count_d  = count_q;
        idx_d    = idx_q;
        state_d  = state_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // Priority: eval > del > insert > ptrLeft > ptrRight.
                if (eval) begin
                    if (count_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = STREAM;
                        idx_d   = '0;
                    end
                end else if (del) begin
                    if (cursor_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        // Slots past count are always blank, so pulling the
                        // tail down one place also blanks slot count-1.
                        for (int i = 0; i < depth - 1; i++) begin
                            if ((CW'(i) + ONE) >= cursor_q) slots_d[i] = slots_q[i+1];
                        end
                        slots_d[depth-1] = '0;
                        cursor_d = cursor_q - ONE;
                        count_d  = count_q - ONE;
                    end
                end else if (insert) begin
                    if (ovr_hit) begin
                        slots_d[cursor_q[AW-1:0]] = dataIn;
                        cursor_d = cursor_q + ONE;
                    end else if (count_q == DEPTH_CW) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 1; i < depth; i++) begin
                            if (CW'(i) > cursor_q) slots_d[i] = slots_q[i-1];
                        end
                        slots_d[cursor_q[AW-1:0]] = dataIn;
                        cursor_d = cursor_q + ONE;
                        count_d  = count_q + ONE;
                    end
                end else if (ptrLeft) begin
                    if (cursor_q == '0) err_d = 1'b1;
                    else                cursor_d = cursor_q - ONE;
                end else if (ptrRight) begin
                    if (cursor_q == count_q) err_d = 1'b1;
                    else                     cursor_d = cursor_q + ONE;
                end
            end
            STREAM: begin
                // Edit commands and eval are ignored here without err.
                if (out_ready) begin
                    if (last_tok) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        if (CLEAR_ON_EVAL) begin
                            for (int i = 0; i < depth; i++) slots_d[i] = '0;
                            cursor_d = '0;
                            count_d  = '0;
                        end
                    end else begin
                        idx_d = idx_q + ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) slots_q[i] <= '0;
            cursor_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            state_q  <= IDLE;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < depth; i++) slots_q[i] <= slots_d[i];
            cursor_q <= cursor_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            err_q    <= err_d;
        end
    end

    for (genvar g = 0; g < depth; g++) begin : g_mem
        assign mem[g*width +: width] = slots_q[g];
    end

    assign cursor    = cursor_q;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_CW);
    assign empty     = (count_q == '0);
    assign busy      = (state_q == STREAM);
    assign out_valid = (state_q == STREAM);
    assign out_data  = (state_q == STREAM) ? slots_q[idx_q[AW-1:0]] : '0;
    assign out_last  = (state_q == STREAM) && last_tok;
    assign err       = err_q;
    assign state_dbg = (state_q == STREAM);

endmodule

// File: tb/tb_edit_buffer.sv
// Self-checking bench for edit_buffer: directed scenarios followed by a
// randomized command stream checked against a queue-based line model.
module tb_edit_buffer;
    localparam int DEPTH = 20;
    localparam int W     = 8;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef OVERWRITE_MODE_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic                   clock, reset;
    logic [W-1:0]           dataIn;
    logic                   insert, del, ptrLeft, ptrRight, eval, mode_ovr, out_ready;
    logic [DEPTH*W-1:0]     mem;
    logic [CW-1:0]          cursor, count;
    logic                   full, empty, busy, out_valid, out_last, err, state_dbg;
    logic [W-1:0]           out_data;

    int checks = 0;
    int errors = 0;

    // Reference model: the line as a queue plus a cursor position.
    logic [W-1:0] m_q[$];
    int           m_cur;
    // Scoreboard of tokens still expected on the stream output.
    logic [W-1:0] exp_q[$];

    edit_buffer #(.depth(DEPTH), .width(W), .CLEAR_ON_EVAL(1'b1)) dut (
        .clock(clock), .reset(reset), .dataIn(dataIn), .insert(insert), .del(del),
        .ptrLeft(ptrLeft), .ptrRight(ptrRight), .eval(eval), .mode_ovr(mode_ovr),
        .out_ready(out_ready), .mem(mem), .cursor(cursor), .count(count), .full(full),
        .empty(empty), .busy(busy), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .err(err), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] slot(input int i);
        return mem[i*W +: W];
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        {insert, del, ptrLeft, ptrRight, eval, mode_ovr, out_ready} = '0;
        dataIn = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        m_q.delete();
        m_cur = 0;
        exp_q.delete();
    endtask

    // ---------------- drivers ----------------
    // Drives one cycle of command pulses (called at posedge+1), returns at
    // the next posedge+1 with all pulses cleared.
    task automatic apply(input bit ev, input bit dl, input bit ins, input bit pl,
                         input bit pr, input logic [W-1:0] d);
        eval = ev; del = dl; insert = ins; ptrLeft = pl; ptrRight = pr; dataIn = d;
        @(posedge clock);
        #1;
        {eval, del, insert, ptrLeft, ptrRight} = '0;
    endtask

    // Line model: applies one IDLE command, reports expected err and stream start.
    task automatic model_cmd(input bit ev, input bit dl, input bit ins, input bit pl,
                             input bit pr, input logic [W-1:0] d, input bit ovr,
                             output bit e, output bit start);
        e = 1'b0;
        start = 1'b0;
        if (ev) begin
            if (m_q.size() == 0) e = 1'b1;
            else                 start = 1'b1;
        end else if (dl) begin
            if (m_cur == 0) e = 1'b1;
            else begin
                m_q.delete(m_cur - 1);
                m_cur--;
            end
        end else if (ins) begin
            if (OVR_EN && ovr && m_cur < m_q.size()) begin
                m_q[m_cur] = d;
                m_cur++;
            end else if (m_q.size() == DEPTH) e = 1'b1;
            else begin
                m_q.insert(m_cur, d);
                m_cur++;
            end
        end else if (pl) begin
            if (m_cur == 0) e = 1'b1;
            else            m_cur--;
        end else if (pr) begin
            if (m_cur == m_q.size()) e = 1'b1;
            else                     m_cur++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (mem !== '0) begin errors++; $display("FAIL reset_mem: got %0h expected 0", mem); end
        checks++; if (cursor !== 0 || count !== 0) begin errors++; $display("FAIL reset_ptrs: got cursor %0d count %0d expected 0 0", cursor, count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty %b full %b expected 1 0", empty, full); end
        checks++; if ({busy, out_valid, out_last, err, state_dbg} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, out_valid, out_last, err, state_dbg}); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    endtask

    task automatic test_insert_edit();
        do_reset();
        apply(0, 0, 1, 0, 0, 8'h31);
        checks++; if (slot(0) !== 8'h31 || cursor !== 1 || count !== 1) begin errors++; $display("FAIL insert_latency: got %0h c%0d n%0d expected 31 c1 n1", slot(0), cursor, count); end
        apply(0, 0, 1, 0, 0, 8'h2B);
        apply(0, 0, 1, 0, 0, 8'h32);
        checks++; if ({slot(0), slot(1), slot(2), slot(3)} !== 32'h312B3200) begin errors++; $display("FAIL insert_three: got %0h expected 312b3200", {slot(0), slot(1), slot(2), slot(3)}); end
        checks++; if (cursor !== 3 || count !== 3 || empty !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL insert_three_ptrs: got c%0d n%0d e%b err%b expected c3 n3 e0 err0", cursor, count, empty, err); end
        apply(0, 0, 0, 1, 0, 8'h00);
        apply(0, 0, 0, 1, 0, 8'h00);
        checks++; if (cursor !== 1 || err !== 1'b0) begin errors++; $display("FAIL ptr_left: got c%0d err%b expected c1 err0", cursor, err); end
        apply(0, 0, 1, 0, 0, 8'h35);
        checks++; if ({slot(0), slot(1), slot(2), slot(3)} !== 32'h31352B32 || cursor !== 2 || count !== 4) begin errors++; $display("FAIL mid_insert: got %0h c%0d n%0d expected 31352b32 c2 n4", {slot(0), slot(1), slot(2), slot(3)}, cursor, count); end
        apply(0, 1, 0, 0, 0, 8'h00);
        checks++; if ({slot(0), slot(1), slot(2), slot(3)} !== 32'h312B3200 || cursor !== 1 || count !== 3) begin errors++; $display("FAIL backspace: got %0h c%0d n%0d expected 312b3200 c1 n3", {slot(0), slot(1), slot(2), slot(3)}, cursor, count); end
    endtask

    // Continues from the 31,2B,32 line left by test_insert_edit.
    task automatic test_stream();
        logic [W-1:0] exp_data [4] = '{8'h31, 8'h2B, 8'h2B, 8'h32};
        bit           exp_last [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bit           rdy      [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        apply(1, 0, 0, 0, 0, 8'h00);
        checks++; if (busy !== 1'b1 || state_dbg !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL eval_start: got busy%b st%b err%b expected 1 1 0", busy, state_dbg, err); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_data[k] || out_last !== exp_last[k]) begin
                errors++;
                $display("FAIL stream_beat%0d: got v%b d%0h l%b expected v1 d%0h l%b", k, out_valid, out_data, out_last, exp_data[k], exp_last[k]);
            end
            out_ready = rdy[k];
            // Stray edits during the stall cycle must be ignored silently.
            if (k == 1) begin insert = 1'b1; del = 1'b1; ptrLeft = 1'b1; eval = 1'b1; dataIn = 8'h55; end
            @(posedge clock);
            #1;
            {insert, del, ptrLeft, eval} = '0;
            out_ready = 1'b0;
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL stream_err%0d: got %b expected 0", k, err); end
        end
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || count !== 0 || cursor !== 0 || mem !== '0) begin errors++; $display("FAIL stream_clear: got busy%b v%b n%0d c%0d expected 0 0 0 0 and blank mem", busy, out_valid, count, cursor); end
    endtask

    task automatic test_empty_bounds();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            apply(k == 2, k == 1, 0, k == 0, 0, 8'h00);
            checks++; if (err !== 1'b1 || count !== 0 || cursor !== 0 || busy !== 1'b0) begin errors++; $display("FAIL empty_reject%0d: got err%b n%0d c%0d busy%b expected 1 0 0 0", k, err, count, cursor, busy); end
            apply(0, 0, 0, 0, 0, 8'h00);
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_width%0d: got %b expected 0", k, err); end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < DEPTH; k++) apply(0, 0, 1, 0, 0, W'(k + 1));
        checks++; if (full !== 1'b1 || count !== DEPTH || cursor !== DEPTH || err !== 1'b0) begin errors++; $display("FAIL fill: got full%b n%0d c%0d err%b expected 1 20 20 0", full, count, cursor, err); end
        apply(0, 0, 1, 0, 0, 8'h77);
        checks++; if (err !== 1'b1 || count !== DEPTH || slot(DEPTH-1) !== 8'd20 || slot(0) !== 8'd1) begin errors++; $display("FAIL overfill: got err%b n%0d last%0h first%0h expected 1 20 14 1", err, count, slot(DEPTH-1), slot(0)); end
        apply(0, 0, 0, 0, 1, 8'h00);
        checks++; if (err !== 1'b1 || cursor !== DEPTH) begin errors++; $display("FAIL ptr_right_end: got err%b c%0d expected 1 20", err, cursor); end
    endtask

    task automatic test_priority();
        do_reset();
        apply(0, 0, 1, 1, 0, 8'h41);
        checks++; if (slot(0) !== 8'h41 || cursor !== 1 || count !== 1 || err !== 1'b0) begin errors++; $display("FAIL prio_ins_left: got %0h c%0d n%0d err%b expected 41 c1 n1 err0", slot(0), cursor, count, err); end
        apply(0, 1, 1, 0, 1, 8'h42);
        checks++; if (slot(0) !== 8'h00 || cursor !== 0 || count !== 0 || err !== 1'b0) begin errors++; $display("FAIL prio_del_ins: got %0h c%0d n%0d err%b expected 0 c0 n0 err0", slot(0), cursor, count, err); end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        apply(0, 0, 1, 0, 0, 8'h31);
        apply(0, 0, 1, 0, 0, 8'h2B);
        apply(1, 0, 0, 0, 0, 8'h00);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        checks++; if (out_data !== 8'h2B || out_valid !== 1'b1) begin errors++; $display("FAIL second_token: got d%0h v%b expected 2b 1", out_data, out_valid); end
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== 1'b0 || count !== 0 || mem !== '0) begin errors++; $display("FAIL async_abort: got v%b busy%b st%b n%0d expected 0 0 0 0", out_valid, busy, state_dbg, count); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        m_q.delete();
        m_cur = 0;
    endtask

    task automatic test_overwrite();
        do_reset();
        apply(0, 0, 1, 0, 0, 8'h31);
        apply(0, 0, 1, 0, 0, 8'h2B);
        apply(0, 0, 0, 1, 0, 8'h00);
        apply(0, 0, 0, 1, 0, 8'h00);
        mode_ovr = 1'b1;
        apply(0, 0, 1, 0, 0, 8'h39);
        mode_ovr = 1'b0;
        if (OVR_EN) begin
            checks++; if ({slot(0), slot(1), slot(2)} !== 24'h392B00 || count !== 2 || cursor !== 1) begin errors++; $display("FAIL overwrite: got %0h n%0d c%0d expected 392b00 n2 c1", {slot(0), slot(1), slot(2)}, count, cursor); end
        end else begin
            checks++; if ({slot(0), slot(1), slot(2)} !== 24'h39312B || count !== 3 || cursor !== 1) begin errors++; $display("FAIL ovr_ignored: got %0h n%0d c%0d expected 39312b n3 c1", {slot(0), slot(1), slot(2)}, count, cursor); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bit ev, dl, ins, pl, pr, e_exp, start;
            logic [W-1:0] d;
            int r, bad;
            r  = $urandom_range(0, 99);
            ev = (r < 6); dl = (r >= 6 && r < 22); ins = (r >= 22 && r < 62);
            pl = (r >= 62 && r < 76); pr = (r >= 76 && r < 90);
            if (r >= 90) begin
                ev = ($urandom_range(0, 7) == 0); dl = 1'($urandom_range(0, 1));
                ins = 1'($urandom_range(0, 1)); pl = 1'($urandom_range(0, 1)); pr = 1'($urandom_range(0, 1));
            end
            d = W'($urandom_range(1, 255));
            mode_ovr = ($urandom_range(0, 3) == 0);
            model_cmd(ev, dl, ins, pl, pr, d, mode_ovr, e_exp, start);
            apply(ev, dl, ins, pl, pr, d);
            mode_ovr = 1'b0;
            bad = -1;
            for (int i = DEPTH - 1; i >= 0; i--) if (slot(i) !== ((i < m_q.size()) ? m_q[i] : '0)) bad = i;
            checks++; if (bad >= 0) begin errors++; $display("FAIL rnd_mem step %0d slot %0d: got %0h expected %0h", n, bad, slot(bad), (bad < m_q.size()) ? m_q[bad] : '0); end
            checks++; if (err !== e_exp || cursor !== m_cur || count !== m_q.size()) begin errors++; $display("FAIL rnd_state step %0d: got err%b c%0d n%0d expected err%b c%0d n%0d", n, err, cursor, count, e_exp, m_cur, m_q.size()); end
            checks++; if (full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0) || busy !== start) begin errors++; $display("FAIL rnd_flags step %0d: got f%b e%b b%b expected f%b e%b b%b", n, full, empty, busy, m_q.size() == DEPTH, m_q.size() == 0, start); end
            if (start) begin
                int budget;
                budget = 0;
                foreach (m_q[i]) exp_q.push_back(m_q[i]);
                while (exp_q.size() > 0 && budget < 100) begin
                    budget++;
                    checks++;
                    if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== exp_q[0] || out_last !== (exp_q.size() == 1)) begin
                        errors++;
                        $display("FAIL rnd_beat step %0d: got v%b b%b d%0h l%b expected v1 b1 d%0h l%b", n, out_valid, busy, out_data, out_last, exp_q[0], exp_q.size() == 1);
                    end
                    out_ready = 1'($urandom_range(0, 1));
                    insert = 1'($urandom_range(0, 1)); del = 1'($urandom_range(0, 1));
                    ptrLeft = 1'($urandom_range(0, 1)); ptrRight = 1'($urandom_range(0, 1));
                    eval = 1'($urandom_range(0, 1));
                    @(posedge clock);
                    #1;
                    {insert, del, ptrLeft, ptrRight, eval} = '0;
                    if (out_ready) exp_q.delete(0);
                    out_ready = 1'b0;
                    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_stream_err step %0d: got %b expected 0", n, err); end
                end
                checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_stream_timeout step %0d: got %0d left expected 0", n, exp_q.size()); exp_q.delete(); end
                m_q.delete();
                m_cur = 0;
                checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || count !== 0 || cursor !== 0) begin errors++; $display("FAIL rnd_stream_end step %0d: got b%b v%b n%0d c%0d expected 0 0 0 0", n, busy, out_valid, count, cursor); end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_insert_edit();
        test_stream();
        test_empty_bounds();
        test_full();
        test_priority();
        test_reset_mid_stream();
        test_overwrite();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edit_buffer.md
Name: edit_buffer

Overview:
- Parametrised successor to the calculator's token store: a cursor-addressed line buffer of `depth` tokens, each `width` bits wide.
- Edit operations: insert at cursor, backspace, and cursor left/right. New over the previous generation: occupancy and status flags, an error pulse, and a valid/ready stream readout on `eval`.
- Sits between the keyboard pulse generator and the evaluator. The display taps `mem` and `cursor` directly.

Parameters:
- depth, 20, number of token slots (≥2)
- width, 8, bits per token; token value 0 means blank
- CLEAR_ON_EVAL, 1, 1 = clear the buffer after the last streamed token; 0 = keep contents

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- dataIn  in  width  token to insert
- insert  in  1  one-cycle command pulse
- del  in  1  one-cycle backspace pulse
- ptrLeft  in  1  one-cycle pulse, cursor left
- ptrRight  in  1  one-cycle pulse, cursor right
- eval  in  1  one-cycle pulse, start stream readout
- mode_ovr  in  1  overwrite mode select (see Optional Feature)
- out_ready  in  1  downstream accepts a token
- mem  out  depth*width  flattened buffer, slot i at bits [i*width +: width]
- cursor  out  clog2(depth+1)  insertion point, 0..count
- count  out  clog2(depth+1)  number of occupied slots
- full  out  1  count == depth
- empty  out  1  count == 0
- busy  out  1  high while in STREAM
- out_data  out  width  streamed token
- out_valid  out  1  out_data is valid
- out_last  out  1  current token is the final one
- err  out  1  one-cycle pulse on a rejected command

Behaviour:
- **Reset (async, reset=0):**
  - All mem slots = 0; cursor = 0; count = 0.
  - empty = 1, full = 0, busy = 0, out_valid = 0, out_last = 0, out_data = 0, err = 0.
  - State = IDLE. Reset mid-stream aborts the stream immediately.
- **FSM states:** IDLE, STREAM.
- **Command arbitration (IDLE):** at most one command per cycle. Priority: eval > del > insert > ptrLeft > ptrRight. Lower-priority commands in the same cycle are dropped silently.
- **Timing:** every IDLE edit takes effect at the next rising edge. mem, cursor and count update together, so latency is 1 cycle.
- **insert:**
  - For i ≥ cursor, slot i+1 ← slot i; slot cursor ← dataIn.
  - cursor+1, count+1.
  - If full: no change and err pulses.
- **del (backspace):**
  - For i ≥ cursor, slot i-1 ← slot i; slot count-1 ← 0.
  - cursor-1, count-1.
  - If cursor == 0: no change and err pulses.
- **ptrLeft:** cursor-1. At cursor == 0: no change, err pulses.
- **ptrRight:** cursor+1. At cursor == count: no change, err pulses.
- **eval:**
  - If count == 0: err pulses and state stays IDLE.
  - Otherwise go to STREAM with internal index = 0. busy and out_valid rise on the next cycle.
- **STREAM:**
  - out_data = slot[index]; out_valid = 1; out_last = (index == count-1).
  - A transfer occurs on out_valid & out_ready, and index then increments.
  - out_data is held stable while out_ready = 0.
  - After the transfer with out_last = 1, next cycle: out_valid = 0, busy = 0, state = IDLE.
  - If CLEAR_ON_EVAL = 1, on that same edge all slots = 0, cursor = 0, count = 0.
  - Edit commands and eval during STREAM are ignored, with no err.
- **err** is registered and high for exactly one cycle per rejected command.
- **Flags:** full and empty are combinational from count.

Optional Feature:
- Macro: OVERWRITE_MODE_EN.
- **Defined:** when mode_ovr = 1 and cursor < count, insert writes slot cursor ← dataIn and cursor+1, with count unchanged and no shift. When cursor == count, insert behaves as a normal insert, including the full check.
- **Undefined:** the mode_ovr port is still present but ignored; insert always shifts.

Test Plan:
1. Reset, insert 0x31, 0x2B, 0x32 → mem[0..2] = 31,2B,32; cursor = 3; count = 3; empty = 0.
2. From (1), ptrLeft twice, insert 0x35 → mem = 31,35,2B,32; cursor = 2; count = 4. Then del → mem = 31,2B,32,00; cursor = 1.
3. Boundaries:
   - Empty buffer: ptrLeft, del and eval each give one err pulse with no state change.
   - Insert `depth` = 20 tokens, then a 21st → full = 1, err pulse, count stays 20.
   - ptrRight at cursor == count → err.
4. Buffer 31,2B,32, eval, out_ready toggling 1,0,1,1 → stream 31,2B,32 in order, out_last only on 32, data held during the stall, then busy = 0 and count = 0 (CLEAR_ON_EVAL = 1).
5. Same cycle insert = 1 and ptrLeft = 1 → only insert applied. Edit pulses during STREAM → no change and no err.
6. Assert reset low mid-stream after the first token → out_valid = 0, count = 0, state IDLE immediately. With OVERWRITE_MODE_EN, mode_ovr = 1, cursor 0 over 31,2B, insert 0x39 → 39,2B, count = 2, cursor = 1.
